// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 serial transmitter fed by a small byte FIFO.
// Ports:
//   clk, reset (async, active-low)   clock and reset
//   write, address, data_in          CPU output bus; PORT_ADDR pushes a byte,
//                                    PORT_ADDR+1 bit 0 clears overflow
//   tx                               serial line, idle high
//   tx_busy                          frame in progress or bytes queued
//   fifo_full, fifo_empty, fifo_count FIFO occupancy
//   overflow                         sticky, a push was dropped
module uart_tx_port #(
  parameter logic [7:0] PORT_ADDR = 8'hF0,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic write,
  input  logic [7:0] address,
  input  logic [7:0] data_in,
  output logic tx,
  output logic tx_busy,
  output logic fifo_full,
  output logic fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic ovf_q, ovf_d;
  logic push, push_ok, pop, clr, baud_done;
  assign push = write && address == PORT_ADDR;
  assign clr = write && address == PORT_ADDR + 8'd1 && data_in[0];
  assign pop = state_q == IDLE && cnt_q != '0;
  // A full FIFO still takes a push when the transmitter frees a slot on the same edge
  assign push_ok = push && (cnt_q != (AW+1)'(FIFO_DEPTH) || pop);
  assign baud_done = baud_q == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      shift_q <= '0;
      baud_q <= '0;
      bit_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      ovf_q <= ovf_d;
    end
  always_ff @(posedge clk)
    if (push_ok) mem_q[wp_q] <= data_in;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d = bit_q;
    baud_d = (state_q == IDLE || baud_done) ? '0 : baud_q + CW'(1);
    wp_d = push_ok ? wp_q + AW'(1) : wp_q;
    rp_d = pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    // A dropped push outranks a simultaneous overflow clear
    ovf_d = (push && !push_ok) ? 1'b1 : clr ? 1'b0 : ovf_q;
    case (state_q)
      IDLE: if (pop) begin
        state_d = START;
        shift_d = mem_q[rp_q];
      end
      START: if (baud_done) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (baud_done) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (baud_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    tx = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
    tx_busy = state_q != IDLE || cnt_q != '0;
    fifo_full = cnt_q == (AW+1)'(FIFO_DEPTH);
    fifo_empty = cnt_q == '0;
    fifo_count = cnt_q;
    overflow = ovf_q;
  end
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: directed and random stimulus checked every cycle against a frame-level model.
module tb_uart_tx_port;
  localparam int CPB = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  logic clk, reset, write;
  logic [7:0] address, data_in;
  logic tx, tx_busy, fifo_full, fifo_empty, overflow;
  logic [2:0] fifo_count;
  int total = 0;
  int bad = 0;
  logic [7:0] mq[$];
  bit m_act = 0;
  int m_k = 0;
  logic [7:0] m_cur = 8'h00;
  bit m_ovf = 0;
  uart_tx_port #(.PORT_ADDR(8'hF0), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .write(write), .address(address), .data_in(data_in),
    .tx(tx), .tx_busy(tx_busy), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_count(fifo_count), .overflow(overflow)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic exp_tx();
    if (!m_act) return 1'b1;
    if (m_k < CPB) return 1'b0;
    if (m_k < 9 * CPB) return m_cur[(m_k - CPB) / CPB];
    return 1'b1;
  endfunction
  task automatic check_all();
    chk("tx", tx, exp_tx());
    chk("tx_busy", tx_busy, m_act || mq.size() != 0);
    chk("fifo_count", fifo_count, mq.size());
    chk("fifo_full", fifo_full, mq.size() == DEPTH);
    chk("fifo_empty", fifo_empty, mq.size() == 0);
    chk("overflow", overflow, m_ovf);
  endtask
  task automatic model_reset();
    mq.delete();
    m_act = 0;
    m_k = 0;
    m_ovf = 0;
  endtask
  task automatic step(input bit w, input logic [7:0] a, input logic [7:0] d);
    bit pop, push, clr, full, drop;
    write = w;
    address = a;
    data_in = d;
    @(posedge clk);
    pop = !m_act && mq.size() != 0;
    full = mq.size() == DEPTH;
    push = w && a == 8'hF0;
    clr = w && a == 8'hF1 && d[0];
    drop = push && full && !pop;
    if (m_act) begin
      m_k++;
      if (m_k == FRAME) m_act = 0;
    end else if (pop) begin
      m_cur = mq.pop_front();
      m_act = 1;
      m_k = 0;
    end
    if (push && !drop) mq.push_back(d);
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    #1;
    check_all();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 8'h00);
  endtask
  task automatic async_reset();
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    #2;
    reset = 1'b1;
  endtask
  initial begin
    reset = 1'b0;
    write = 1'b0;
    address = 8'h00;
    data_in = 8'h00;
    #12;
    model_reset();
    check_all();
    reset = 1'b1;
    step(1, 8'hF0, 8'h55);
    idle(FRAME + 5);
    step(1, 8'hF0, 8'hA3);
    step(1, 8'hF0, 8'h0F);
    idle(2 * FRAME + 10);
    for (int i = 1; i <= 6; i++) step(1, 8'hF0, 8'(i));
    chk("ovf_after_burst", overflow, 1'b1);
    idle(5 * FRAME + 10);
    step(1, 8'hF1, 8'h00);
    step(1, 8'hF1, 8'h01);
    step(1, 8'hF2, 8'h77);
    idle(3);
    for (int i = 0; i < 5; i++) step(1, 8'hF0, 8'h10 + 8'(i));
    for (int i = 0; i < 3 * FRAME && !(!m_act && mq.size() == DEPTH); i++) step(0, 8'h00, 8'h00);
    step(1, 8'hF0, 8'h99);
    chk("full_pop_push_count", fifo_count, 3'd4);
    idle(6 * FRAME);
    step(1, 8'hF0, 8'hFF);
    step(1, 8'hF0, 8'h11);
    step(1, 8'hF0, 8'h22);
    for (int i = 0; i < FRAME && !(m_act && m_k == 4 * CPB + 5); i++) step(0, 8'h00, 8'h00);
    async_reset();
    chk("reset_mid_tx", tx, 1'b1);
    idle(FRAME + 20);
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] a, d;
      int sel;
      sel = int'($urandom_range(0, 9));
      a = sel < 5 ? 8'hF0 : sel < 7 ? 8'hF1 : sel < 8 ? 8'hF2 : 8'($urandom);
      d = 8'($urandom);
      if ($urandom_range(0, 1999) == 0) async_reset();
      else step($urandom_range(0, 99) < 4, a, d);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
- Memory-mapped serial transmit port on the 8-bit CPU output bus, alongside the output port flip-flops in the 0xF0..0xFF window.
- Captures CPU byte writes to its data address into a small FIFO, then serializes each byte as 8N1 UART frames on a single pin.
- Gives the CPU a character output path without polling per bit.
- Status outputs are wired to input ports so firmware can poll them.

Parameters:
- PORT_ADDR, 8'hF0: data address. A write here pushes data_in into the FIFO. PORT_ADDR+1 is the control address.
- CLKS_PER_BIT, 16: clk cycles per serial bit, minimum 2.
- FIFO_DEPTH, 4: FIFO entries; must be a power of two, minimum 2.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low.
- write, input, 1: CPU write strobe, sampled on clk rising edge.
- address, input, 8: CPU address bus.
- data_in, input, 8: CPU write data.
- tx, output, 1: serial output, idle high.
- tx_busy, output, 1: high while the FIFO is non-empty or a frame is in progress.
- fifo_full, output, 1: FIFO holds FIFO_DEPTH entries.
- fifo_empty, output, 1: FIFO holds 0 entries.
- fifo_count, output, log2(FIFO_DEPTH)+1: number of FIFO entries.
- overflow, output, 1: sticky; a push was dropped.

Behaviour:
- Reset (asynchronous, active-low, any time including mid-frame):
  - tx=1, state=IDLE, FIFO pointers and count = 0.
  - fifo_empty=1, fifo_full=0, tx_busy=0, overflow=0.
  - Baud and bit counters = 0.
  - A partially sent frame is abandoned; tx returns high immediately.
- All outputs are registered or decoded directly from registers; no combinational path from write, address or data_in to any output.
- Push:
  - push = write && address==PORT_ADDR.
  - Accepted when count<FIFO_DEPTH, or when a pop happens on the same edge.
  - If not accepted, data is dropped and overflow is set to 1 on that edge.
- Control write: write && address==PORT_ADDR+1 with data_in[0]=1 clears overflow. If a clear and an overflow-setting push could coincide, set wins. Other control bits are ignored.
- Writes to any other address are ignored.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo FIFO_DEPTH.
  - Count updates on the same edge as a push or pop; push and pop together leave count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO is non-empty at an edge: pop the head into an 8-bit shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit. After bit index 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency:
  - Push on edge N into an empty, idle FIFO: pop on edge N+1, tx falls after edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have exactly 1 extra tx=1 cycle (the IDLE cycle) between stop bit and next start bit.
- tx_busy = (state!=IDLE) || !fifo_empty.
  - Asserts the cycle after an accepted push.
  - Deasserts the cycle after STOP completes with the FIFO empty.
- The FIFO can accept pushes while a frame is transmitting.

Test Plan:
- Reset, then write 8'h55 to 8'hF0 → push on edge N; tx low from N+1 for 16 cycles. Then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then 16 cycles high. tx_busy drops after 161 cycles total.
- Write 8'hA3 then 8'h0F on consecutive cycles → two frames, LSB first: 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0. Exactly 1 idle-high cycle between the frames. fifo_count peaks at 1.
- Six writes 8'h01..8'h06 back-to-back while idle → the first pops immediately; the FIFO fills to 4; the 6th write is dropped and sets overflow=1. Only 8'h01..8'h05 appear on tx.
- overflow=1, write 8'h01 to 8'hF1 → overflow=0 next cycle. Write 8'h00 to 8'hF1 → overflow unchanged. Write 8'h77 to 8'hF2 → no push, count unchanged.
- FIFO full and the FSM pops on the same edge as a push → push accepted, count stays 4, overflow stays 0.
- Assert reset during DATA bit 3 of 8'hFF with 2 entries queued → tx=1, count=0, fifo_empty=1 and tx_busy=0 immediately. After release, no frame is sent until a new write.
